// File: rtl/sprite_regs_pkg.sv
// Shared definitions for the sprite register bank and the sprite renderer:
// the bus address map, the register count and the power-on sprite layout.
package sprite_regs_pkg;

    localparam int NUM_REGS  = 15;
    localparam int SCORE_IDX = 10;

    typedef enum logic [8:0] {
        ADDR_DINO_X     = 9'd0,
        ADDR_DINO_Y     = 9'd1,
        ADDR_JUMP_X     = 9'd2,
        ADDR_JUMP_Y     = 9'd3,
        ADDR_DUCK_X     = 9'd4,
        ADDR_DUCK_Y     = 9'd5,
        ADDR_S_CAC_X    = 9'd6,
        ADDR_S_CAC_Y    = 9'd7,
        ADDR_GODZILLA_X = 9'd8,
        ADDR_GODZILLA_Y = 9'd9,
        ADDR_SCORE      = 9'd10,
        ADDR_SCORE_X    = 9'd11,
        ADDR_SCORE_Y    = 9'd12,
        ADDR_POWERUP_X  = 9'd13,
        ADDR_POWERUP_Y  = 9'd14,
        ADDR_CTRL       = 9'd16,
        ADDR_STATUS     = 9'd17,
        ADDR_IRQ_ACK    = 9'd18,
        ADDR_FRAME      = 9'd19
    } reg_addr_e;

    // Initial sprite positions shown before software writes anything
    localparam logic [NUM_REGS-1:0][7:0] RESET_VALS = '{
        0: 8'd100,  1: 8'd100,  2: 8'd200,  3: 8'd150,  4: 8'd250,
        5: 8'd200,  6: 8'd180,  7: 8'd100,  8: 8'd100,  9: 8'd230,
        10: 8'd0,   11: 8'd225, 12: 8'd240, 13: 8'd130, 14: 8'd210
    };

    // Default for register idx; registers beyond the known layout start at 0
    function automatic logic [7:0] reset_value(input int idx);
        if (idx >= 0 && idx < NUM_REGS) begin
            return RESET_VALS[idx];
        end
        return 8'd0;
    endfunction

endpackage

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite register bank. Software writes shadow registers at
// any time; the whole set is copied to the renderer-facing active registers
// in one edge at the start of vertical blanking, so a frame never shows a
// half-updated scene.
module sprite_reg_bank #(
    parameter int NUM_REGS = sprite_regs_pkg::NUM_REGS,
    parameter int FRAME_W  = 16,
    parameter int VACTIVE  = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [8:0]            address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [10:0]           hcount,
    input  logic [9:0]            vcount,
    output logic [NUM_REGS*8-1:0] active_regs,
    output logic                  irq
);
    import sprite_regs_pkg::*;

    logic [7:0]         shadow [NUM_REGS];
    logic [7:0]         active [NUM_REGS];
    logic               pending;
    logic               auto_commit;
    logic [FRAME_W-1:0] frame_cnt;
    logic [31:0]        rd_value;

    logic bus_wr;
    logic bus_rd;
    logic commit_pt;
    logic commit_fire;

    assign bus_wr      = chipselect && write;
    assign bus_rd      = chipselect && read;
    assign commit_pt   = (hcount == 11'd0) && (vcount == VACTIVE[9:0]);
    assign commit_fire = commit_pt && (pending || auto_commit);

    // Shadow registers take bus writes; score keeps only its low nibble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= reset_value(i);
            end
        end else if (bus_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (address == 9'(i)) begin
                    if (i == SCORE_IDX) begin
                        shadow[i] <= {4'b0000, writedata[3:0]};
                    end else begin
                        shadow[i] <= writedata[7:0];
                    end
                end
            end
        end
    end

    // Active registers copy the pre-edge shadow set only when a commit fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active[i] <= reset_value(i);
            end
        end else if (commit_fire) begin
            active <= shadow;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active_out
        assign active_regs[g*8 +: 8] = active[g];
    end

    // Control state: a request written during a commit survives for the next
    // frame, and a commit's irq set beats a same-cycle acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= 1'b0;
            auto_commit <= 1'b0;
            irq         <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (commit_pt) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (commit_fire) begin
                pending <= 1'b0;
            end
            if (bus_wr && address == ADDR_CTRL) begin
                auto_commit <= writedata[1];
                if (writedata[0]) begin
                    pending <= 1'b1;
                end
            end
            if (bus_wr && address == ADDR_IRQ_ACK && writedata[0]) begin
                irq <= 1'b0;
            end
            if (commit_fire) begin
                irq <= 1'b1;
            end
        end
    end

    // Read mux; anything not decoded reads as zero
    always_comb begin
        rd_value = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address == 9'(i)) begin
                rd_value = {24'd0, shadow[i]};
            end
        end
        if (address == ADDR_CTRL) begin
            rd_value = {30'd0, auto_commit, pending};
        end else if (address == ADDR_STATUS) begin
            rd_value = {30'd0, irq, pending};
        end else if (address == ADDR_FRAME) begin
            rd_value = 32'(frame_cnt);
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (bus_rd) begin
            readdata <= rd_value;
        end
    end

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Bench for sprite_reg_bank: bus stimulus pushes expected read data into a
// scoreboard queue, and a monitor compares it when the read data lands.
module tb_sprite_reg_bank;

    localparam int NUM_REGS = 15;
    localparam int VACTIVE  = 480;

    logic                  clk        = 1'b0;
    logic                  reset_n    = 1'b0;
    logic                  chipselect = 1'b0;
    logic                  write      = 1'b0;
    logic                  read       = 1'b0;
    logic [8:0]            address    = 9'd0;
    logic [31:0]           writedata  = 32'd0;
    logic [31:0]           readdata;
    logic [10:0]           hcount     = 11'd5;
    logic [9:0]            vcount     = 10'd0;
    logic [NUM_REGS*8-1:0] active_regs;
    logic                  irq;

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_frame = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic rd_due = 1'b0;

    localparam logic [7:0] DEFAULTS [NUM_REGS] = '{
        8'd100, 8'd100, 8'd200, 8'd150, 8'd250, 8'd200, 8'd180, 8'd100,
        8'd100, 8'd230, 8'd0, 8'd225, 8'd240, 8'd130, 8'd210
    };

    always #5 clk = ~clk;

    sprite_reg_bank #(
        .NUM_REGS(NUM_REGS),
        .FRAME_W (16),
        .VACTIVE (VACTIVE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .hcount     (hcount),
        .vcount     (vcount),
        .active_regs(active_regs),
        .irq        (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] activeByte(input int idx);
        return active_regs[idx*8 +: 8];
    endfunction

    // Track which cycles carried a read so the monitor knows when data is due
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_due <= 1'b0;
        end else begin
            rd_due <= chipselect && read;
        end
    end

    // Monitor: compare read data against the oldest expected entry
    always @(negedge clk) begin
        if (rd_due) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, expected no read data", readdata);
            end else begin
                mon_e = sb.pop_front();
                checkOutput(mon_e.name, readdata, mon_e.value);
            end
        end
    end

    // Drive one bus cycle starting at a falling edge; optionally place the
    // raster at the commit point for that same cycle
    task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                 input logic [8:0] addr, input logic [31:0] data,
                                 input logic at_commit);
        chipselect = cs;
        write      = wr;
        read       = rd;
        address    = addr;
        writedata  = data;
        if (at_commit) begin
            hcount    = 11'd0;
            vcount    = 10'(VACTIVE);
            exp_frame = (exp_frame + 1) & 32'hFFFF;
        end
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 9'd0;
        writedata  = 32'd0;
        hcount     = 11'd5;
        vcount     = 10'd0;
    endtask

    task automatic writeReg(input logic [8:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, data, 1'b0);
    endtask

    task automatic writeAtCommit(input logic [8:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, data, 1'b1);
    endtask

    task automatic readReg(input string name, input logic [8:0] addr,
                           input logic [31:0] expected);
        exp_t e;
        e.name  = name;
        e.value = expected;
        sb.push_back(e);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, 32'd0, 1'b0);
    endtask

    task automatic holdCommit(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1);
        end
    endtask

    initial begin
        #3_000_000;
        n_tests++;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("readdata_reset", readdata, 32'd0);
        checkOutput("irq_reset", 32'(irq), 32'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            checkOutput($sformatf("active_reset_%0d", i), 32'(activeByte(i)), 32'(DEFAULTS[i]));
        end
        readReg("rd_dino_x_reset", 9'd0, 32'd100);

        // Shadow write without commit request leaves active untouched
        writeReg(9'd0, 32'd42);
        readReg("rd_dino_x_shadow", 9'd0, 32'd42);
        holdCommit(1);
        checkOutput("active_dino_x_no_commit", 32'(activeByte(0)), 32'd100);
        readReg("rd_frame_1", 9'd19, 32'd1);
        readReg("rd_status_idle", 9'd17, 32'd0);

        // Requested commit
        writeReg(9'd16, 32'd1);
        readReg("rd_status_pending", 9'd17, 32'd1);
        holdCommit(1);
        checkOutput("active_dino_x_commit", 32'(activeByte(0)), 32'd42);
        checkOutput("irq_after_commit", 32'(irq), 32'd1);
        readReg("rd_status_after_commit", 9'd17, 32'd2);
        writeReg(9'd18, 32'd1);
        checkOutput("irq_after_ack", 32'(irq), 32'd0);
        readReg("rd_frame_2", 9'd19, 32'd2);

        // Auto commit; a shadow write in the commit cycle waits a frame
        writeReg(9'd16, 32'd2);
        writeAtCommit(9'd3, 32'd77);
        checkOutput("active_jump_y_same_cycle", 32'(activeByte(3)), 32'd150);
        checkOutput("irq_auto_commit", 32'(irq), 32'd1);
        readReg("rd_jump_y_shadow", 9'd3, 32'd77);
        writeReg(9'd18, 32'd1);
        checkOutput("irq_ack_2", 32'(irq), 32'd0);
        writeAtCommit(9'd16, 32'd1);
        checkOutput("active_jump_y_next_frame", 32'(activeByte(3)), 32'd77);
        checkOutput("irq_auto_commit_2", 32'(irq), 32'd1);
        readReg("rd_status_req_in_commit", 9'd17, 32'd3);

        // Score masking, read-only and unmapped addresses
        writeReg(9'd10, 32'h1F);
        readReg("rd_score_masked", 9'd10, 32'h0F);
        checkOutput("active_score_unchanged", 32'(activeByte(10)), 32'd0);
        writeReg(9'd17, 32'hAB);
        readReg("rd_status_ro", 9'd17, 32'd3);
        readReg("rd_unmapped_25", 9'd25, 32'd0);
        readReg("rd_unmapped_15", 9'd15, 32'd0);

        // Frame counter to all-ones, then wrap with a coincident acknowledge
        holdCommit(65531);
        readReg("rd_frame_ffff", 9'd19, 32'h0000FFFF);
        readReg("rd_frame_model", 9'd19, 32'(exp_frame));
        checkOutput("active_score_commit", 32'(activeByte(10)), 32'd15);
        writeReg(9'd18, 32'd1);
        checkOutput("irq_ack_3", 32'(irq), 32'd0);
        writeReg(9'd16, 32'd1);
        writeAtCommit(9'd18, 32'd1);
        checkOutput("irq_set_wins", 32'(irq), 32'd1);
        readReg("rd_frame_wrap", 9'd19, 32'd0);
        readReg("rd_status_after_wrap", 9'd17, 32'd2);

        // Reset in the middle of a requested commit
        writeReg(9'd1, 32'd9);
        writeReg(9'd16, 32'd1);
        hcount  = 11'd0;
        vcount  = 10'(VACTIVE);
        reset_n = 1'b0;
        @(negedge clk);
        hcount  = 11'd5;
        vcount  = 10'd0;
        #2;
        reset_n = 1'b1;
        exp_frame = 0;
        @(negedge clk);
        checkOutput("active_dino_y_after_reset", 32'(activeByte(1)), 32'd100);
        checkOutput("irq_after_reset", 32'(irq), 32'd0);
        checkOutput("readdata_after_reset", readdata, 32'd0);
        readReg("rd_status_after_reset", 9'd17, 32'd0);
        readReg("rd_frame_after_reset", 9'd19, 32'd0);
        readReg("rd_dino_y_after_reset", 9'd1, 32'd100);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
